// File: rtl/branch_resolve_unit.sv
// Branch resolution from ALU compare flags with a 2-entry output buffer toward fetch.
// Define BRU_STATS_EN to add saturating taken/not-taken counters on popped entries.
module branch_resolve_unit #(
  parameter int XLEN = 32
`ifdef BRU_STATS_EN
  , parameter int STAT_W = 16
`endif
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      in_flags,
  input  logic [2:0]      in_funct3,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_imm,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_taken,
  output logic [XLEN-1:0] out_next_pc,
  output logic            out_illegal
`ifdef BRU_STATS_EN
  , output logic [STAT_W-1:0] stat_taken
  , output logic [STAT_W-1:0] stat_ntaken
`endif
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} count_t;

  count_t state, state_next;

  logic            flag_v, flag_c, flag_n, flag_z;
  logic            dec_taken, dec_illegal;
  logic [XLEN-1:0] dec_next_pc;

  logic            tail_taken, tail_illegal;
  logic [XLEN-1:0] tail_next_pc;

  logic push, pop;

  assign {flag_v, flag_c, flag_n, flag_z} = in_flags;

  always_comb begin
    dec_taken   = 1'b0;
    dec_illegal = 1'b0;
    case (in_funct3)
      3'b000:  dec_taken = flag_z;
      3'b001:  dec_taken = !flag_z;
      3'b100:  dec_taken = flag_n ^ flag_v;
      3'b101:  dec_taken = !(flag_n ^ flag_v);
      3'b110:  dec_taken = !flag_c;
      3'b111:  dec_taken = flag_c;
      default: dec_illegal = 1'b1;
    endcase
    dec_next_pc = dec_taken ? (in_pc + in_imm) : (in_pc + XLEN'(4));
  end

  // in_ready looks only at registered occupancy so fetch stalls never reach EX combinationally
  assign in_ready  = (state != TWO) && !flush;
  assign out_valid = (state != EMPTY);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready && !flush;

  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = EMPTY;
    end else begin
      case (state)
        EMPTY: if (push) state_next = ONE;
        ONE: begin
          if (push && !pop)      state_next = TWO;
          else if (!push && pop) state_next = EMPTY;
        end
        TWO:     if (pop) state_next = ONE;
        default: state_next = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_next;
  end

  // Head register drives out_* directly; the tail only fills when the head is occupied and held
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_taken    <= 1'b0;
      out_next_pc  <= '0;
      out_illegal  <= 1'b0;
      tail_taken   <= 1'b0;
      tail_next_pc <= '0;
      tail_illegal <= 1'b0;
    end else if (!flush) begin
      case (state)
        EMPTY: begin
          if (push) begin
            out_taken   <= dec_taken;
            out_next_pc <= dec_next_pc;
            out_illegal <= dec_illegal;
          end
        end
        ONE: begin
          if (push && pop) begin
            out_taken   <= dec_taken;
            out_next_pc <= dec_next_pc;
            out_illegal <= dec_illegal;
          end else if (push) begin
            tail_taken   <= dec_taken;
            tail_next_pc <= dec_next_pc;
            tail_illegal <= dec_illegal;
          end
        end
        TWO: begin
          if (pop) begin
            out_taken   <= tail_taken;
            out_next_pc <= tail_next_pc;
            out_illegal <= tail_illegal;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef BRU_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_taken  <= '0;
      stat_ntaken <= '0;
    end else if (pop) begin
      if (out_taken) begin
        if (stat_taken != '1) stat_taken <= stat_taken + 1'b1;
      end else begin
        if (stat_ntaken != '1) stat_ntaken <= stat_ntaken + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: operand-level reference model plus queue scoreboard.
// Stat counter checks are compiled in when BRU_STATS_EN is defined.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready;
  logic [3:0]  in_flags;
  logic [2:0]  in_funct3;
  logic [31:0] in_pc, in_imm;
  logic        out_valid, out_ready, out_taken, out_illegal;
  logic [31:0] out_next_pc;
`ifdef BRU_STATS_EN
  logic [15:0] stat_taken, stat_ntaken;
`endif

  branch_resolve_unit #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_flags(in_flags), .in_funct3(in_funct3), .in_pc(in_pc), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_taken(out_taken),
    .out_next_pc(out_next_pc), .out_illegal(out_illegal)
`ifdef BRU_STATS_EN
    , .stat_taken(stat_taken), .stat_ntaken(stat_ntaken)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        taken;
    logic [31:0] npc;
    logic        illegal;
  } ent_t;

  ent_t        q[$];
  ent_t        cur;
  int          tests = 0;
  int          fails = 0;
  int unsigned m_taken = 0;
  int unsigned m_ntaken = 0;

  // Flags come from a real A-B subtraction; the expected outcome from direct operand comparison
  task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] pc, input logic [31:0] imm);
    logic [31:0] diff;
    diff = a - b;
    in_flags  = {(a[31] != b[31]) && (diff[31] != a[31]), a >= b, diff[31], diff == 32'd0};
    in_funct3 = f3;
    in_pc     = pc;
    in_imm    = imm;
    cur.illegal = (f3 == 3'b010) || (f3 == 3'b011);
    case (f3)
      3'b000:  cur.taken = (a == b);
      3'b001:  cur.taken = (a != b);
      3'b100:  cur.taken = ($signed(a) < $signed(b));
      3'b101:  cur.taken = ($signed(a) >= $signed(b));
      3'b110:  cur.taken = (a < b);
      3'b111:  cur.taken = (a >= b);
      default: cur.taken = 1'b0;
    endcase
    cur.npc = cur.taken ? pc + imm : pc + 32'd4;
  endtask

  task automatic rand_branch();
    logic [31:0] edges [5];
    logic [31:0] a, b;
    edges = '{32'h0, 32'h1, 32'h7fffffff, 32'h80000000, 32'hffffffff};
    a = $urandom;
    case ($urandom_range(0, 3))
      0: b = a;
      1: b = $urandom;
      2: b = a + (($urandom_range(0, 1) == 1) ? 32'd1 : 32'hffffffff);
      default: begin
        a = edges[$urandom_range(0, 4)];
        b = edges[$urandom_range(0, 4)];
      end
    endcase
    applyStimulus(3'($urandom_range(0, 7)), a, b, {$urandom} & 32'hfffffffc,
                  {{20{1'b0}}, 12'($urandom)} - 32'h800);
  endtask

  // Scoreboard update for the cycle whose inputs are currently driven, then advance one clock
  task automatic advance();
    bit can_push;
    can_push = (q.size() < 2) && !flush;
    if (!rst_n) begin
      q.delete();
      m_taken  = 0;
      m_ntaken = 0;
    end else if (flush) begin
      q.delete();
    end else begin
      if (q.size() > 0 && out_ready) begin
        if (q[0].taken) m_taken  = (m_taken  == 65535) ? m_taken  : m_taken + 1;
        else            m_ntaken = (m_ntaken == 65535) ? m_ntaken : m_ntaken + 1;
        void'(q.pop_front());
      end
      if (in_valid && can_push) q.push_back(cur);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    applyStimulus(3'b000, 32'd0, 32'd0, 32'd0, 32'd0);
    advance();
    advance();
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if ({out_valid, out_taken, out_next_pc, out_illegal} !== 35'd0) begin
      fails++; $display("[TB] FAIL reset_outputs: got %h expected 0", {out_valid, out_taken, out_next_pc, out_illegal});
    end
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
`ifdef BRU_STATS_EN
    tests++;
    if ({stat_taken, stat_ntaken} !== 32'd0) begin
      fails++; $display("[TB] FAIL reset_stats: got %h expected 0", {stat_taken, stat_ntaken});
    end
`endif
    advance();
  endtask

  task automatic test_decisions();
    out_ready = 1'b1;
    applyStimulus(3'b101, 32'd2, 32'd1, 32'h100, 32'h20);
    in_valid = 1'b1;
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL bge_in_ready: got %b expected 1", in_ready); end
    advance();
    in_valid = 1'b0;
    @(negedge clk);
    tests++;
    if ({out_valid, out_taken, out_next_pc, out_illegal} !== {1'b1, 1'b1, 32'h120, 1'b0}) begin
      fails++; $display("[TB] FAIL bge_taken: got v%b t%b pc%h i%b expected v1 t1 pc00000120 i0",
                        out_valid, out_taken, out_next_pc, out_illegal);
    end
    advance();
    // BEQ not-taken, then BLTU taken with the same operands, back to back
    applyStimulus(3'b000, 32'd1, 32'd2, 32'h100, 32'h40);
    in_valid = 1'b1;
    @(negedge clk);
    advance();
    applyStimulus(3'b110, 32'd1, 32'd2, 32'h100, 32'h40);
    @(negedge clk);
    tests++;
    if ({out_valid, out_taken, out_next_pc} !== {1'b1, 1'b0, 32'h104}) begin
      fails++; $display("[TB] FAIL beq_ntaken: got v%b t%b pc%h expected v1 t0 pc00000104", out_valid, out_taken, out_next_pc);
    end
    advance();
    in_valid = 1'b0;
    @(negedge clk);
    tests++;
    if ({out_valid, out_taken, out_next_pc} !== {1'b1, 1'b1, 32'h140}) begin
      fails++; $display("[TB] FAIL bltu_taken: got v%b t%b pc%h expected v1 t1 pc00000140", out_valid, out_taken, out_next_pc);
    end
    advance();
    // Signed-overflow compare: 0x7fffffff - 0x80000000
    for (int i = 0; i < 3; i++) begin
      logic [2:0] f3s [3];
      logic       exp_t [3];
      f3s   = '{3'b100, 3'b111, 3'b110};
      exp_t = '{1'b0, 1'b0, 1'b1};
      applyStimulus(f3s[i], 32'h7fffffff, 32'h80000000, 32'h400, 32'h8);
      in_valid = 1'b1;
      @(negedge clk);
      advance();
      in_valid = 1'b0;
      @(negedge clk);
      tests++;
      if (out_taken !== exp_t[i]) begin
        fails++; $display("[TB] FAIL overflow_cmp_f3_%b: got %b expected %b", f3s[i], out_taken, exp_t[i]);
      end
      advance();
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    applyStimulus(3'b000, 32'd5, 32'd5, 32'h200, 32'h10);
    @(negedge clk);
    advance();
    applyStimulus(3'b001, 32'd5, 32'd5, 32'h300, 32'h10);
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL bp_second_ready: got %b expected 1", in_ready); end
    advance();
    applyStimulus(3'b111, 32'd9, 32'd5, 32'h500, 32'h10);
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b0) begin fails++; $display("[TB] FAIL bp_third_ready: got %b expected 0", in_ready); end
    tests++;
    if ({out_valid, out_next_pc} !== {1'b1, 32'h210}) begin
      fails++; $display("[TB] FAIL bp_head_hold: got v%b pc%h expected v1 pc00000210", out_valid, out_next_pc);
    end
    advance();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    tests++;
    if ({out_valid, out_taken, out_next_pc} !== {1'b1, 1'b1, 32'h210}) begin
      fails++; $display("[TB] FAIL bp_drain_first: got v%b t%b pc%h expected v1 t1 pc00000210", out_valid, out_taken, out_next_pc);
    end
    advance();
    @(negedge clk);
    tests++;
    if ({out_valid, out_taken, out_next_pc, in_ready} !== {1'b1, 1'b0, 32'h304, 1'b1}) begin
      fails++; $display("[TB] FAIL bp_drain_second: got v%b t%b pc%h r%b expected v1 t0 pc00000304 r1",
                        out_valid, out_taken, out_next_pc, in_ready);
    end
    advance();
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL bp_drained: got %b expected 0", out_valid); end
    advance();
  endtask

  task automatic test_flush();
    int unsigned st_t, st_n;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      rand_branch();
      @(negedge clk);
      advance();
    end
    st_t = m_taken;
    st_n = m_ntaken;
    flush = 1'b1;
    out_ready = 1'b1;
    rand_branch();
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b0) begin fails++; $display("[TB] FAIL flush_in_ready: got %b expected 0", in_ready); end
    advance();
    flush = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      tests++;
      if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL flush_empty_%0d: got %b expected 0", i, out_valid); end
      advance();
    end
`ifdef BRU_STATS_EN
    tests++;
    if ({stat_taken, stat_ntaken} !== {st_t[15:0], st_n[15:0]}) begin
      fails++; $display("[TB] FAIL flush_stats: got %h expected %h", {stat_taken, stat_ntaken}, {st_t[15:0], st_n[15:0]});
    end
`else
    if (st_t + st_n > 32'hffff_ffff - 1) $display("[TB] note: stats counters large");
`endif
  endtask

  task automatic test_illegal_wrap();
    int unsigned nt_before;
    nt_before = m_ntaken;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    applyStimulus(3'b010, 32'd3, 32'd3, 32'hfffffffc, 32'h40);
    @(negedge clk);
    advance();
    in_valid = 1'b0;
    @(negedge clk);
    tests++;
    if ({out_valid, out_illegal, out_taken, out_next_pc} !== {1'b1, 1'b1, 1'b0, 32'h0}) begin
      fails++; $display("[TB] FAIL illegal_wrap: got v%b i%b t%b pc%h expected v1 i1 t0 pc00000000",
                        out_valid, out_illegal, out_taken, out_next_pc);
    end
    advance();
`ifdef BRU_STATS_EN
    @(negedge clk);
    tests++;
    if ({16'd0, stat_ntaken} !== nt_before + 1) begin
      fails++; $display("[TB] FAIL illegal_ntaken_stat: got %0d expected %0d", stat_ntaken, nt_before + 1);
    end
    advance();
`endif
  endtask

  task automatic test_random_traffic();
    for (int i = 0; i < 400; i++) begin
      rand_branch();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      @(negedge clk);
      tests++;
      if (out_valid !== (q.size() > 0)) begin
        fails++; $display("[TB] FAIL rand_out_valid@%0d: got %b expected %b", i, out_valid, q.size() > 0);
      end
      if (q.size() > 0) begin
        tests++;
        if ({out_taken, out_next_pc, out_illegal} !== q[0]) begin
          fails++; $display("[TB] FAIL rand_head@%0d: got %h expected %h", i, {out_taken, out_next_pc, out_illegal}, q[0]);
        end
      end
      tests++;
      if (in_ready !== ((q.size() < 2) && !flush)) begin
        fails++; $display("[TB] FAIL rand_in_ready@%0d: got %b expected %b", i, in_ready, (q.size() < 2) && !flush);
      end
`ifdef BRU_STATS_EN
      tests++;
      if ({stat_taken, stat_ntaken} !== {m_taken[15:0], m_ntaken[15:0]}) begin
        fails++; $display("[TB] FAIL rand_stats@%0d: got %h expected %h", i, {stat_taken, stat_ntaken}, {m_taken[15:0], m_ntaken[15:0]});
      end
`endif
      advance();
    end
    flush = 1'b0;
  endtask

  task automatic test_reset_midop();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(3'b111, 32'd7, 32'd1, 32'h1000, 32'h80);
      @(negedge clk);
      advance();
    end
    rst_n = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    advance();
    rst_n = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    tests++;
    if ({out_valid, out_taken, out_next_pc, out_illegal} !== 35'd0) begin
      fails++; $display("[TB] FAIL reset_midop: got %h expected 0", {out_valid, out_taken, out_next_pc, out_illegal});
    end
`ifdef BRU_STATS_EN
    tests++;
    if ({stat_taken, stat_ntaken} !== 32'd0) begin
      fails++; $display("[TB] FAIL reset_midop_stats: got %h expected 0", {stat_taken, stat_ntaken});
    end
`endif
    advance();
  endtask

  initial begin
    test_reset();
    test_decisions();
    test_back_to_back();
    test_flush();
    test_illegal_wrap();
    test_random_traffic();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
